// File: rtl/contador_a_pkg.sv
// Shared definitions for the contador_a counter: operation codes and default width.
package contador_a_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        MODO_UP   = 2'b00,
        MODO_DN1  = 2'b01,
        MODO_DN3  = 2'b10,
        MODO_LOAD = 2'b11
    } modo_e;

endpackage

// File: rtl/contador_a_next.sv
// Next-state rule table for contador_a: {next_q, wrap} from (q, modo, d).
// Latency: combinational, no state.
// Backpressure: none; the caller decides whether to apply the result.
module contador_next
    import contador_a_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap
);

    // Two guard bits so a 3 subtrahend still produces a borrow when WIDTH=1.
    localparam int DW = WIDTH + 2;

    logic [DW-1:0] q_ext;
    logic [DW-1:0] res;

    assign q_ext = {2'b00, q};

    always_comb begin
        res    = q_ext;
        next_q = q;
        wrap   = 1'b0;
        case (modo)
            MODO_UP: begin
                res    = q_ext + DW'(1);
                next_q = res[WIDTH-1:0];
                wrap   = res[WIDTH];
            end
            MODO_DN1: begin
                res    = q_ext - DW'(1);
                next_q = res[WIDTH-1:0];
                wrap   = res[DW-1];
            end
            MODO_DN3: begin
                res    = q_ext - DW'(3);
                next_q = res[WIDTH-1:0];
                wrap   = res[DW-1];
            end
            MODO_LOAD: begin
                next_q = d;
                wrap   = 1'b0;
            end
            default: begin
                next_q = q;
                wrap   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/contador_a.sv
// Loadable up/down-1/down-3 counter with one-cycle ripple-carry-out on every wrap.
// Latency: 1 cycle from sampled inputs to Q/rco.
// Backpressure: none; enable=0 holds Q and forces rco low.
module contador_a
    import contador_a_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic [WIDTH-1:0] nxt_q;
    logic             nxt_wrap;

    contador_next #(.WIDTH(WIDTH)) u_next (
        .q      (q_q),
        .modo   (modo),
        .d      (D),
        .next_q (nxt_q),
        .wrap   (nxt_wrap)
    );

    // rco is recomputed every cycle so it can never stretch past one edge.
    always_comb begin
        q_d   = q_q;
        rco_d = 1'b0;
        if (enable) begin
            q_d   = nxt_q;
            rco_d = nxt_wrap;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign Q   = q_q;
    assign rco = rco_q;

endmodule

// File: tb/tb_contador_a.sv
// Directed and randomized checks of contador_a against hand-computed values and an independent model.
module tb_contador_a;

    logic       clk;
    logic       reset_L;
    logic       enable;
    logic [1:0] modo;
    logic [3:0] D;
    logic [3:0] Q;
    logic       rco;

    int vectors = 0;
    int fails   = 0;

    int dn3_q[7]   = '{15, 12, 9, 6, 3, 0, 13};
    int dn3_rco[7] = '{1, 0, 0, 0, 0, 0, 1};

    contador_a #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .enable  (enable),
        .modo    (modo),
        .D       (D),
        .Q       (Q),
        .rco     (rco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] eq, input logic er);
        vectors++;
        assert (Q === eq && rco === er)
        else begin
            fails++;
            $error("FAIL %s: Q=%0d rco=%b, expected Q=%0d rco=%b", tag, Q, rco, eq, er);
        end
    endtask

    task automatic step(input logic en, input logic [1:0] m, input logic [3:0] d);
        enable = en;
        modo   = m;
        D      = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] mq;
        logic       mr;
        logic       en;
        logic [1:0] m;
        logic [3:0] d;

        reset_L = 1'b0;
        enable  = 1'b0;
        modo    = 2'b00;
        D       = 4'd0;
        #2;
        check("reset_t0", 4'd0, 1'b0);
        reset_L = 1'b1;

        step(1'b1, 2'b11, 4'd9);
        check("load9", 4'd9, 1'b0);
        #2 reset_L = 1'b0;
        #1 check("async_rst_from9", 4'd0, 1'b0);
        #1 reset_L = 1'b1;
        step(1'b0, 2'b00, 4'd0);
        check("hold_after_rst", 4'd0, 1'b0);

        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 2'b00, 4'd0);
            check($sformatf("up_%0d", i), 4'(i % 16), (i == 16));
        end

        step(1'b1, 2'b11, 4'd2);
        check("load2", 4'd2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 2'b10, 4'd0);
            check($sformatf("dn3_%0d", i), 4'(dn3_q[i]), dn3_rco[i][0]);
        end

        step(1'b1, 2'b11, 4'd1);
        check("load1", 4'd1, 1'b0);
        step(1'b1, 2'b01, 4'd0);
        check("dn1_0", 4'd0, 1'b0);
        step(1'b1, 2'b01, 4'd0);
        check("dn1_15", 4'd15, 1'b1);
        step(1'b1, 2'b01, 4'd0);
        check("dn1_14", 4'd14, 1'b0);
        step(1'b0, 2'b01, 4'd0);
        check("hold14_a", 4'd14, 1'b0);
        step(1'b0, 2'b00, 4'd3);
        check("hold14_b", 4'd14, 1'b0);

        step(1'b1, 2'b11, 4'd15);
        check("load15", 4'd15, 1'b0);
        step(1'b1, 2'b00, 4'd0);
        check("load_then_wrap", 4'd0, 1'b1);

        step(1'b1, 2'b11, 4'd15);
        check("load_eq_noflag_a", 4'd15, 1'b0);
        step(1'b1, 2'b11, 4'd15);
        check("load_eq_noflag_b", 4'd15, 1'b0);

        step(1'b1, 2'b11, 4'd6);
        check("load6", 4'd6, 1'b0);
        step(1'b1, 2'b00, 4'd0);
        check("up7", 4'd7, 1'b0);
        #2 reset_L = 1'b0;
        #1 check("async_rst_from7", 4'd0, 1'b0);
        step(1'b1, 2'b00, 4'd0);
        check("rst_held_over_edge", 4'd0, 1'b0);
        #4 reset_L = 1'b1;
        step(1'b1, 2'b00, 4'd0);
        check("first_edge_after_rst", 4'd1, 1'b0);

        mq = 4'd1;
        for (int i = 0; i < 200; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            m  = 2'($urandom_range(0, 3));
            d  = 4'($urandom_range(0, 15));
            mr = 1'b0;
            if (en) begin
                case (m)
                    2'b00: begin mr = (mq == 4'd15); mq = mq + 4'd1; end
                    2'b01: begin mr = (mq == 4'd0);  mq = mq - 4'd1; end
                    2'b10: begin mr = (mq < 4'd3);   mq = mq - 4'd3; end
                    default: begin mr = 1'b0; mq = d; end
                endcase
            end
            step(en, m, d);
            check($sformatf("rand_%0d", i), mq, mr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
